adpcm_chan_sched: RTL and testbench
===================================

ADPCM_CHAN_SCHED -- requirements
Module: adpcm_chan_sched

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent ADPCM channels time-sharing one IMA ADPCM decoder core.
REQ-002 The block SHALL have parameter CH_W, default 2: channel tag width, equal to clog2(NUM_CH).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port chPCM, input, 4*NUM_CH bits: per-channel ADPCM nibble; channel c occupies [4c+3:4c].
REQ-006 The block SHALL have port chValid, input, NUM_CH bits: per-channel nibble valid.
REQ-007 The block SHALL have port chReady, output, NUM_CH bits: one-hot accept pulse; a nibble transfers when chValid[c] and chReady[c] are both high.
REQ-008 The block SHALL have ports cfgWrite (input, 1 bit), cfgChan (input, CH_W bits), cfgPredict (input, 16 bits) and cfgIndex (input, 7 bits): channel context initialisation.
REQ-009 The block SHALL have ports decPCM (output, 4), decValid (output, 1), decPredictSamp (output, 16), decStepIndex (output, 7) and decStateLoad (output, 1): drive to the decoder core.
REQ-010 The block SHALL have ports decSamp (input, 16) and decOutValid (input, 1): decoder core output.
REQ-011 The block SHALL have ports outSamp (output, 16), outChan (output, CH_W) and outValid (output, 1): tagged decoded sample; outValid is a 1-cycle pulse.
REQ-012 The block SHALL have port err, output, 1 bit: sticky decoder-timeout flag, cleared only by reset.

Function
REQ-013 The block SHALL hold a context store of NUM_CH entries, each holding a 16-bit predictor and a 7-bit step index.
REQ-014 The FSM SHALL have states IDLE, LOAD, SETTLE, DECODE, WAIT and STORE.
REQ-015 IDLE: when any chValid bit is high, the block SHALL round-robin grant, starting from the channel after the last granted one, pulse chReady for that channel in the same cycle, latch the nibble and channel, and go to LOAD.
REQ-016 LOAD: the block SHALL assert decStateLoad for exactly 1 cycle, with decPredictSamp/decStepIndex taken from the granted channel's context.
REQ-017 SETTLE: the block SHALL wait 1 cycle so the core's registered step-size lookup reflects the loaded index.
REQ-018 DECODE: the block SHALL assert decValid for exactly 1 cycle with decPCM equal to the latched nibble, and SHALL compute the new step index in that cycle.
REQ-019 New step index: nibble[2:0] of 0-3 gives -1 and 4/5/6/7 gives +2/+4/+6/+8; the result SHALL saturate to 0..88.
REQ-020 WAIT: the block SHALL stay in WAIT until decOutValid is high, then go to STORE; the expected arrival is the 2nd cycle after DECODE.
REQ-021 If decOutValid has not arrived within 4 cycles in WAIT, the block SHALL set err, skip the context write, emit no output and return to IDLE.
REQ-022 STORE: the block SHALL write decSamp and the new index into the granted channel's context, then return to IDLE.
REQ-023 The block SHALL register outSamp=decSamp, outChan=granted channel and outValid=1, visible in the cycle after decOutValid.
REQ-024 Latency SHALL be: accept at cycle a; LOAD a+1; SETTLE a+2; DECODE a+3; decOutValid a+5; outValid a+6. Throughput SHALL be 1 nibble per 6 cycles; the next grant is possible at a+6.
REQ-025 decStateLoad and decValid SHALL never be high in the same cycle, and both SHALL be low outside LOAD and DECODE respectively.
REQ-026 cfgWrite SHALL write the context of cfgChan in the same cycle, in any state.
REQ-027 If cfgWrite targets the in-flight channel in any cycle from LOAD through STORE, the configured value SHALL win: the STORE write is suppressed, but outValid is still emitted.
REQ-028 A channel holding chValid high SHALL receive a grant within NUM_CH transactions (starvation-free).
REQ-029 No data SHALL be lost on a multi-channel request: non-granted channels see no chReady and keep their data.

Reset
REQ-030 With reset low at a clock edge, the block SHALL set: FSM to IDLE; all contexts to predictor 0, index 0; the round-robin pointer to NUM_CH-1 (channel 0 first); chReady, decValid, decStateLoad, outValid and err to 0; outSamp and outChan to 0.
REQ-031 Reset mid-transaction SHALL abort the transaction with no context write and no outValid.

Structure
REQ-032 Package adpcm_pkg SHALL hold the FSM state enum, the step-index maximum (88), the timeout constant (4) and the index-adaptation function.
REQ-033 Sub-module adpcm_rr_arbiter SHALL implement the NUM_CH-way round-robin grant with a pointer update on accept.

Verification
REQ-034 Scenario: reset; cfg ch1 predict 0, index 0; ch1 nibble 7 -> decStateLoad at a+1 with 0/0, decValid at a+3, outValid at a+6 with outSamp=13 and outChan=1; ch1 context becomes 13/8.
REQ-035 Scenario: all 4 chValid held high from reset -> grants in order 0,1,2,3,0, spaced 6 cycles apart.
REQ-036 Scenario: ch0 at index 0, nibble 0 -> stored index 0 (low clamp); cfg ch2 index 85, nibble 7 -> stored index 88 (high clamp).
REQ-037 Scenario: cfgWrite ch0 (predict 100, index 10) while ch0 is in WAIT -> outValid still pulses; ch0 context reads 100/10 on the next LOAD.
REQ-038 Scenario: decoder model withholds decOutValid -> err=1 after 4 WAIT cycles, no outValid, FSM back in IDLE, next request served.
REQ-039 Scenario: reset low during SETTLE -> no outValid; all contexts 0/0; a following request behaves as in REQ-034.

Source files
------------

// File: rtl/adpcm_pkg.sv
// adpcm_pkg: shared definitions for the multi-channel ADPCM scheduler.
//   state_t       - scheduler FSM states
//   STEP_IDX_MAX  - upper bound of the IMA step index
//   DEC_TIMEOUT   - cycles tolerated in WAIT before flagging a decoder timeout
//   adapt_index() - IMA step-index adaptation with saturation to 0..STEP_IDX_MAX
package adpcm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_DECODE,
    ST_WAIT,
    ST_STORE
  } state_t;

  localparam int          STEP_IDX_MAX = 88;
  localparam int unsigned DEC_TIMEOUT  = 4;

  function automatic logic [6:0] adapt_index(input logic [6:0] idx, input logic [3:0] nib);
    int sum;
    case (nib[2:0])
      3'd4:    sum = int'(idx) + 2;
      3'd5:    sum = int'(idx) + 4;
      3'd6:    sum = int'(idx) + 6;
      3'd7:    sum = int'(idx) + 8;
      default: sum = int'(idx) - 1;
    endcase
    if (sum < 0) begin
      sum = 0;
    end else if (sum > STEP_IDX_MAX) begin
      sum = STEP_IDX_MAX;
    end
    return 7'(sum);
  endfunction

endpackage

// File: rtl/adpcm_chan_sched_if.sv
// adpcm_chan_sched_if: bundles the scheduler's channel, configuration,
// decoder-core and output signals.
//   master - environment side (drives nibbles, config and decoder results)
//   slave  - scheduler side
interface adpcm_chan_sched_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
);
  logic [4*NUM_CH-1:0] chPCM;
  logic [NUM_CH-1:0]   chValid;
  logic [NUM_CH-1:0]   chReady;
  logic                cfgWrite;
  logic [CH_W-1:0]     cfgChan;
  logic [15:0]         cfgPredict;
  logic [6:0]          cfgIndex;
  logic [3:0]          decPCM;
  logic                decValid;
  logic [15:0]         decPredictSamp;
  logic [6:0]          decStepIndex;
  logic                decStateLoad;
  logic [15:0]         decSamp;
  logic                decOutValid;
  logic [15:0]         outSamp;
  logic [CH_W-1:0]     outChan;
  logic                outValid;
  logic                err;

  modport master (
    output chPCM, chValid, cfgWrite, cfgChan, cfgPredict, cfgIndex, decSamp, decOutValid,
    input  chReady, decPCM, decValid, decPredictSamp, decStepIndex, decStateLoad,
           outSamp, outChan, outValid, err
  );

  modport slave (
    input  chPCM, chValid, cfgWrite, cfgChan, cfgPredict, cfgIndex, decSamp, decOutValid,
    output chReady, decPCM, decValid, decPredictSamp, decStepIndex, decStateLoad,
           outSamp, outChan, outValid, err
  );
endinterface

// File: rtl/adpcm_rr_arbiter.sv
// adpcm_rr_arbiter: NUM_CH-way round-robin arbiter.
//   req       - per-channel request
//   accept    - grant is taken this cycle; pointer moves to the granted channel
//   grant     - one-hot grant (combinational)
//   grant_idx - index of the granted channel
//   grant_vld - some request is granted
// Search starts at the channel after the last accepted one; the pointer
// resets to NUM_CH-1 so channel 0 is first.
module adpcm_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_vld
);

  logic [CH_W-1:0] ptr_q, ptr_d;
  int unsigned     cand;
  logic [CH_W-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand     = (32'(ptr_q) + i) % NUM_CH;
      cand_idx = CH_W'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld       = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && grant_vld) begin
      ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= CH_W'(NUM_CH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adpcm_chan_sched.sv
// adpcm_chan_sched: time-shares one IMA ADPCM decoder core between NUM_CH
// channels, keeping a predictor/step-index context per channel.
//   clock, reset          - rising-edge clock, synchronous active-low reset
//   chPCM/chValid/chReady - per-channel nibble input, one-hot accept pulse
//   cfg*                  - direct context write (wins over a pending STORE)
//   dec*                  - decoder core load/decode drive and result return
//   outSamp/outChan/outValid - channel-tagged decoded sample, 1-cycle pulse
//   err                   - sticky decoder timeout flag
module adpcm_chan_sched
  import adpcm_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4*NUM_CH-1:0] chPCM,
  input  logic [NUM_CH-1:0]   chValid,
  output logic [NUM_CH-1:0]   chReady,
  input  logic                cfgWrite,
  input  logic [CH_W-1:0]     cfgChan,
  input  logic [15:0]         cfgPredict,
  input  logic [6:0]          cfgIndex,
  output logic [3:0]          decPCM,
  output logic                decValid,
  output logic [15:0]         decPredictSamp,
  output logic [6:0]          decStepIndex,
  output logic                decStateLoad,
  input  logic [15:0]         decSamp,
  input  logic                decOutValid,
  output logic [15:0]         outSamp,
  output logic [CH_W-1:0]     outChan,
  output logic                outValid,
  output logic                err
);

  state_t state_q, state_d;

  logic [15:0]     ctx_pred_q [NUM_CH];
  logic [15:0]     ctx_pred_d [NUM_CH];
  logic [6:0]      ctx_idx_q  [NUM_CH];
  logic [6:0]      ctx_idx_d  [NUM_CH];

  logic [CH_W-1:0] chan_q, chan_d;
  logic [3:0]      nib_q, nib_d;
  logic [6:0]      idx_new_q, idx_new_d;
  logic [2:0]      wait_cnt_q, wait_cnt_d;
  logic            cfg_hit_q, cfg_hit_d;
  logic [15:0]     out_samp_q, out_samp_d;
  logic [CH_W-1:0] out_chan_q, out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic            err_q, err_d;

  logic [NUM_CH-1:0] arb_grant;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_vld;
  logic              arb_accept;
  logic              take;
  logic              timeout;

  adpcm_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (chValid),
    .accept    (arb_accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  assign timeout = (state_q == ST_WAIT) && !decOutValid &&
                   (wait_cnt_q == 3'(DEC_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // STORE also arbitrates so the next grant lands 6 cycles after the last.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (take) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_DECODE;
      ST_DECODE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (decOutValid) begin
          state_d = ST_STORE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_STORE:  state_d = take ? ST_LOAD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arb_accept     = reset && ((state_q == ST_IDLE) || (state_q == ST_STORE));
    take           = arb_accept && arb_vld;
    chReady        = arb_accept ? arb_grant : '0;
    decStateLoad   = 1'b0;
    decPredictSamp = '0;
    decStepIndex   = '0;
    decValid       = 1'b0;
    decPCM         = '0;
    if (state_q == ST_LOAD) begin
      decStateLoad   = 1'b1;
      decPredictSamp = ctx_pred_q[chan_q];
      decStepIndex   = ctx_idx_q[chan_q];
    end
    if (state_q == ST_DECODE) begin
      decValid = 1'b1;
      decPCM   = nib_q;
    end
  end

  always_comb begin
    chan_d      = chan_q;
    nib_d       = nib_q;
    idx_new_d   = idx_new_q;
    wait_cnt_d  = '0;
    cfg_hit_d   = cfg_hit_q;
    out_valid_d = 1'b0;
    out_samp_d  = out_samp_q;
    out_chan_d  = out_chan_q;
    err_d       = err_q | timeout;
    ctx_pred_d  = ctx_pred_q;
    ctx_idx_d   = ctx_idx_q;

    if (take) begin
      chan_d    = arb_idx;
      cfg_hit_d = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (arb_idx == CH_W'(c)) begin
          nib_d = chPCM[4*c +: 4];
        end
      end
    end else if ((state_q != ST_IDLE) && cfgWrite && (cfgChan == chan_q)) begin
      cfg_hit_d = 1'b1;
    end

    if (state_q == ST_DECODE) begin
      idx_new_d = adapt_index(ctx_idx_q[chan_q], nib_q);
    end

    if (state_q == ST_WAIT) begin
      if (decOutValid) begin
        out_valid_d = 1'b1;
        out_samp_d  = decSamp;
        out_chan_d  = chan_q;
      end else begin
        wait_cnt_d = wait_cnt_q + 3'd1;
      end
    end

    // out_samp_q still holds the decoded sample during STORE; a config write
    // to the same entry in the same cycle is applied last and therefore wins.
    if ((state_q == ST_STORE) && !cfg_hit_q) begin
      ctx_pred_d[chan_q] = out_samp_q;
      ctx_idx_d[chan_q]  = idx_new_q;
    end
    if (cfgWrite) begin
      ctx_pred_d[cfgChan] = cfgPredict;
      ctx_idx_d[cfgChan]  = cfgIndex;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        ctx_pred_q[c] <= '0;
        ctx_idx_q[c]  <= '0;
      end
      chan_q      <= '0;
      nib_q       <= '0;
      idx_new_q   <= '0;
      wait_cnt_q  <= '0;
      cfg_hit_q   <= 1'b0;
      out_samp_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ctx_pred_q  <= ctx_pred_d;
      ctx_idx_q   <= ctx_idx_d;
      chan_q      <= chan_d;
      nib_q       <= nib_d;
      idx_new_q   <= idx_new_d;
      wait_cnt_q  <= wait_cnt_d;
      cfg_hit_q   <= cfg_hit_d;
      out_samp_q  <= out_samp_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign outSamp  = out_samp_q;
  assign outChan  = out_chan_q;
  assign outValid = out_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_adpcm_chan_sched.sv
// tb_adpcm_chan_sched: directed bench for adpcm_chan_sched with a behavioural
// decoder core that returns a chosen sample two cycles after decValid.
module tb_adpcm_chan_sched;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  logic clock;
  logic reset;

  adpcm_chan_sched_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

  adpcm_chan_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .chPCM          (bus.chPCM),
    .chValid        (bus.chValid),
    .chReady        (bus.chReady),
    .cfgWrite       (bus.cfgWrite),
    .cfgChan        (bus.cfgChan),
    .cfgPredict     (bus.cfgPredict),
    .cfgIndex       (bus.cfgIndex),
    .decPCM         (bus.decPCM),
    .decValid       (bus.decValid),
    .decPredictSamp (bus.decPredictSamp),
    .decStepIndex   (bus.decStepIndex),
    .decStateLoad   (bus.decStateLoad),
    .decSamp        (bus.decSamp),
    .decOutValid    (bus.decOutValid),
    .outSamp        (bus.outSamp),
    .outChan        (bus.outChan),
    .outValid       (bus.outValid),
    .err            (bus.err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decoder core model
  logic        resp_en   = 1'b1;
  logic [15:0] resp_samp = 16'h0;
  logic        dv_d1     = 1'b0;
  always @(posedge clock) begin
    dv_d1           <= bus.decValid;
    bus.decOutValid <= dv_d1 & resp_en;
    bus.decSamp     <= (dv_d1 & resp_en) ? resp_samp : 16'h0;
  end

  // Monitors
  int unsigned cyc         = 0;
  int          ov_cnt      = 0;
  logic        overlap_seen = 1'b0;
  int          g_ch[$];
  int unsigned g_cyc[$];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.outValid === 1'b1) ov_cnt <= ov_cnt + 1;
    if (bus.decStateLoad === 1'b1 && bus.decValid === 1'b1) overlap_seen <= 1'b1;
    if (reset === 1'b1) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (bus.chValid[c] === 1'b1 && bus.chReady[c] === 1'b1) begin
          g_ch.push_back(c);
          g_cyc.push_back(cyc);
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input int ch, input logic [15:0] pred, input logic [6:0] idx);
    bus.cfgWrite   = 1'b1;
    bus.cfgChan    = CH_W'(ch);
    bus.cfgPredict = pred;
    bus.cfgIndex   = idx;
    tick();
    bus.cfgWrite   = 1'b0;
  endtask

  // One transaction with fixed latency; starts in IDLE, ends one cycle after outValid.
  task automatic txn(input int ch, input logic [3:0] nib, input logic [15:0] samp,
                     input logic [15:0] exp_pred, input logic [6:0] exp_idx,
                     input bit cfg_in_wait);
    resp_samp           = samp;
    bus.chPCM           = '0;
    bus.chPCM[4*ch +: 4] = nib;
    bus.chValid         = '0;
    bus.chValid[ch]     = 1'b1;
    #1;
    chk("accept_ready", 32'(bus.chReady), 32'(1 << ch));
    tick();                                     // a+1 LOAD
    bus.chValid = '0;
    chk("load_strobe", 32'(bus.decStateLoad), 32'd1);
    chk("load_pred", 32'(bus.decPredictSamp), 32'(exp_pred));
    chk("load_idx", 32'(bus.decStepIndex), 32'(exp_idx));
    chk("load_ready_low", 32'(bus.chReady), 32'd0);
    tick();                                     // a+2 SETTLE
    chk("settle_quiet", 32'({bus.decStateLoad, bus.decValid}), 32'd0);
    tick();                                     // a+3 DECODE
    chk("decode_valid", 32'(bus.decValid), 32'd1);
    chk("decode_pcm", 32'(bus.decPCM), 32'(nib));
    chk("decode_noload", 32'(bus.decStateLoad), 32'd0);
    tick();                                     // a+4 WAIT
    chk("wait_novalid", 32'(bus.decValid), 32'd0);
    if (cfg_in_wait) begin
      bus.cfgWrite   = 1'b1;
      bus.cfgChan    = CH_W'(ch);
      bus.cfgPredict = 16'd100;
      bus.cfgIndex   = 7'd10;
    end
    tick();                                     // a+5 decOutValid
    bus.cfgWrite = 1'b0;
    chk("early_out", 32'(bus.outValid), 32'd0);
    tick();                                     // a+6 outValid
    chk("out_valid", 32'(bus.outValid), 32'd1);
    chk("out_samp", 32'(bus.outSamp), 32'(samp));
    chk("out_chan", 32'(bus.outChan), 32'(ch));
    tick();                                     // a+7
    chk("out_pulse", 32'(bus.outValid), 32'd0);
  endtask

  int ov0;
  int gstart;

  initial begin
    reset          = 1'b0;
    bus.chPCM      = '0;
    bus.chValid    = '0;
    bus.cfgWrite   = 1'b0;
    bus.cfgChan    = '0;
    bus.cfgPredict = '0;
    bus.cfgIndex   = '0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_ready", 32'(bus.chReady), 32'd0);
    chk("rst_outvalid", 32'(bus.outValid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_outsamp", 32'(bus.outSamp), 32'd0);
    chk("rst_outchan", 32'(bus.outChan), 32'd0);
    chk("rst_dec", 32'({bus.decValid, bus.decStateLoad}), 32'd0);
    reset = 1'b1;
    tick();

    // Basic decode on ch1; context then reads 13/8
    cfg(1, 16'd0, 7'd0);
    txn(1, 4'd7, 16'd13, 16'd0, 7'd0, 1'b0);
    txn(1, 4'd0, 16'd40, 16'd13, 7'd8, 1'b0);   // ch1 -> 40/7

    // Index clamps
    txn(0, 4'd0, 16'd5, 16'd0, 7'd0, 1'b0);      // ch0 -> 5/0
    txn(0, 4'd0, 16'd6, 16'd5, 7'd0, 1'b0);      // low clamp, ch0 -> 6/0
    cfg(2, 16'd0, 7'd85);
    txn(2, 4'd7, 16'd20, 16'd0, 7'd85, 1'b0);    // ch2 -> 20/88
    txn(2, 4'd0, 16'd21, 16'd20, 7'd88, 1'b0);   // high clamp observed

    // Config write during WAIT wins over STORE
    txn(0, 4'd4, 16'd77, 16'd6, 7'd0, 1'b1);
    txn(0, 4'd0, 16'd1, 16'd100, 7'd10, 1'b0);

    // Decoder timeout
    resp_en         = 1'b0;
    bus.chPCM       = '0;
    bus.chPCM[15:12] = 4'd1;
    bus.chValid     = 4'b1000;
    #1;
    chk("to_accept", 32'(bus.chReady), 32'h8);
    tick();                                     // a+1
    bus.chValid = '0;
    ov0 = ov_cnt;
    tick(); tick();                             // a+3
    chk("to_decode", 32'(bus.decValid), 32'd1);
    tick();                                     // a+4 .. a+7 in WAIT
    for (int k = 0; k < 4; k++) begin
      chk("to_err_early", 32'(bus.err), 32'd0);
      tick();
    end
    chk("to_err_set", 32'(bus.err), 32'd1);
    chk("to_no_out", 32'(bus.outValid), 32'd0);
    chk("to_out_count", 32'(ov_cnt - ov0), 32'd0);
    resp_en = 1'b1;
    txn(3, 4'd2, 16'd9, 16'd0, 7'd0, 1'b0);      // ch3 context untouched
    chk("err_sticky", 32'(bus.err), 32'd1);

    // Reset during SETTLE
    bus.chPCM      = '0;
    bus.chPCM[7:4] = 4'd5;
    bus.chValid    = 4'b0010;
    #1;
    chk("rm_accept", 32'(bus.chReady), 32'h2);
    tick();                                     // LOAD
    bus.chValid = '0;
    chk("rm_load_pred", 32'(bus.decPredictSamp), 32'd40);
    chk("rm_load_idx", 32'(bus.decStepIndex), 32'd7);
    tick();                                     // SETTLE
    reset = 1'b0;
    ov0 = ov_cnt;
    tick();
    reset = 1'b1;
    chk("rm_err_clr", 32'(bus.err), 32'd0);
    for (int k = 0; k < 8; k++) tick();
    chk("rm_no_out", 32'(ov_cnt - ov0), 32'd0);
    chk("rm_no_decode", 32'(bus.decValid), 32'd0);
    txn(1, 4'd7, 16'd13, 16'd0, 7'd0, 1'b0);

    // All channels held valid from reset: grants 0,1,2,3,0 six cycles apart
    reset       = 1'b0;
    bus.chPCM   = '0;
    bus.chValid = 4'b1111;
    resp_samp   = 16'd3;
    tick(); tick();
    chk("rr_rst_ready", 32'(bus.chReady), 32'd0);
    gstart = g_ch.size();
    reset = 1'b1;
    for (int k = 0; k < 32; k++) tick();
    bus.chValid = '0;
    chk("rr_grant_count_ok", 32'(g_ch.size() - gstart >= 5), 32'd1);
    if (g_ch.size() - gstart >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", 32'(g_ch[gstart+k]), 32'(k % 4));
        if (k > 0) chk("rr_spacing", g_cyc[gstart+k] - g_cyc[gstart+k-1], 32'd6);
      end
    end

    chk("load_decode_exclusive", 32'(overlap_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
